// File: rtl/mem_access_unit.sv
// Execution-side memory access unit: issues ALU writebacks directly and runs
// req/ack load/store transactions on the data bus, stalling the pipeline meanwhile.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [2:0]        memctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        dest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [4:0]        dest_q, dest_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rfWe_q, rfWe_d;
    logic [4:0]        rfWaddr_q, rfWaddr_d;
    logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;

    logic isMemOp;
    logic isIllegal;
    logic isMisaligned;

    assign isMemOp      = memctrl[2] | memctrl[1];
    assign isIllegal    = memctrl[2] & memctrl[1];
    assign isMisaligned = (alu_result[1:0] != 2'b00);

    // Every output comes straight from a register; reset clears all of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            dest_q     <= '0;
            rdata_q    <= '0;
            rfWe_q     <= 1'b0;
            rfWaddr_q  <= '0;
            rfWdata_q  <= '0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            dest_q     <= dest_d;
            rdata_q    <= rdata_d;
            rfWe_q     <= rfWe_d;
            rfWaddr_q  <= rfWaddr_d;
            rfWdata_q  <= rfWdata_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        dest_d     = dest_q;
        rdata_d    = rdata_q;
        rfWe_d     = 1'b0;
        rfWaddr_d  = rfWaddr_q;
        rfWdata_d  = rfWdata_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid && isMemOp) begin
                    if (isIllegal || isMisaligned) begin
                        err_d = 1'b1;
                    end else begin
                        // memWe_q doubles as the remembered op for the writeback decision.
                        memReq_d   = 1'b1;
                        memWe_d    = memctrl[1];
                        memAddr_d  = ADDR_W'(alu_result);
                        memWdata_d = wdata;
                        dest_d     = dest;
                        cnt_d      = '0;
                        state_d    = REQ;
                    end
                end else if (valid && memctrl[0] && (dest != 5'd0)) begin
                    rfWe_d    = 1'b1;
                    rfWaddr_d = dest;
                    rfWdata_d = alu_result;
                end
            end

            REQ: begin
                if (mem_ack) begin
                    rdata_d  = mem_rdata;
                    memReq_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed REQ cycle without an ack: abandon the access.
                    memReq_d = 1'b0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (!memWe_q && (dest_q != 5'd0)) begin
                    rfWe_d    = 1'b1;
                    rfWaddr_d = dest_q;
                    rfWdata_d = rdata_q;
                end
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign stall     = stall_q;
    assign rf_we     = rfWe_q;
    assign rf_waddr  = rfWaddr_q;
    assign rf_wdata  = rfWdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset corner
// case, and randomized commands checked against a per-transaction timeline model.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid;
    logic [2:0]        memctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        dest;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              err;

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  dst;
        int          ackDelay;
        logic [31:0] rd;
        bit          noise;
    } vec_t;

    vec_t vecs[$];

    mem_access_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .memctrl   (memctrl),
        .alu_result(alu_result),
        .wdata     (wdata),
        .dest      (dest),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit eReq, input bit eWe,
                               input logic [31:0] eAddr, input logic [31:0] eWdata,
                               input bit eStall, input bit eRfWe, input logic [4:0] eWaddr,
                               input logic [31:0] eRfData, input bit eErr);
        vectorCount++;
        cmp({tag, " mem_req"}, 32'(mem_req), 32'(eReq));
        if (eReq) begin
            cmp({tag, " mem_we"}, 32'(mem_we), 32'(eWe));
            cmp({tag, " mem_addr"}, mem_addr, eAddr);
            cmp({tag, " mem_wdata"}, mem_wdata, eWdata);
        end
        cmp({tag, " stall"}, 32'(stall), 32'(eStall));
        cmp({tag, " rf_we"}, 32'(rf_we), 32'(eRfWe));
        cmp({tag, " err"}, 32'(err), 32'(eErr));
        if (eRfWe) begin
            cmp({tag, " rf_waddr"}, 32'(rf_waddr), 32'(eWaddr));
            cmp({tag, " rf_wdata"}, rf_wdata, eRfData);
        end
    endtask

    // Issues one command and checks every cycle until the unit is idle again.
    // Expected behaviour is a timeline derived from the ack delay (cycles after mem_req rises).
    task automatic applyStimulus(input string nm, input logic [2:0] ctrl, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] dst, input int ackDelay,
                                 input logic [31:0] rd, input bit noise);
        bit memOp, legal, acked, isLoad, isAlu;
        bit eReq, eStall, eRf, eErr;
        int n, reqCycles;
        memOp     = ctrl[2] | ctrl[1];
        legal     = memOp && !(ctrl[2] && ctrl[1]) && (alu[1:0] == 2'b00);
        isLoad    = ctrl[2];
        isAlu     = (ctrl == 3'b001);
        acked     = ackDelay < TIMEOUT;
        reqCycles = acked ? ackDelay + 1 : TIMEOUT;
        if (!legal)     n = 1;
        else if (acked) n = ackDelay + 3;
        else            n = (ackDelay + 2 > TIMEOUT + 1) ? ackDelay + 2 : TIMEOUT + 1;

        valid      = 1'b1;
        memctrl    = ctrl;
        alu_result = alu;
        wdata      = wd;
        dest       = dst;
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(posedge clk);
            #1;
            if (!legal) begin
                eReq   = 1'b0;
                eStall = 1'b0;
                eErr   = memOp;
                eRf    = isAlu && (dst != 5'd0);
            end else begin
                eReq = (cyc <= reqCycles);
                if (acked) begin
                    eStall = (cyc <= ackDelay + 2);
                    eErr   = 1'b0;
                    eRf    = (cyc == ackDelay + 3) && isLoad && (dst != 5'd0);
                end else begin
                    eStall = (cyc <= TIMEOUT);
                    eErr   = (cyc == TIMEOUT + 1);
                    eRf    = 1'b0;
                end
            end
            checkOutput($sformatf("%s c%0d", nm, cyc), eReq, ctrl[1], alu, wd, eStall, eRf, dst,
                        isAlu ? alu : rd, eErr);
            if (noise && eStall) begin
                valid      = 1'($urandom_range(0, 1));
                memctrl    = 3'($urandom);
                alu_result = $urandom;
                wdata      = $urandom;
                dest       = 5'($urandom);
            end else begin
                valid = 1'b0;
            end
            mem_ack   = (cyc == ackDelay + 1);
            mem_rdata = mem_ack ? rd : $urandom;
        end
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a;
        int          d;
        bit          b;

        reset      = 1'b1;
        valid      = 1'b0;
        memctrl    = 3'b000;
        alu_result = '0;
        wdata      = '0;
        dest       = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        cmp("reset mem_we", 32'(mem_we), 32'h0);
        cmp("reset mem_addr", mem_addr, 32'h0);
        cmp("reset mem_wdata", mem_wdata, 32'h0);
        cmp("reset rf_waddr", 32'(rf_waddr), 32'h0);
        cmp("reset rf_wdata", rf_wdata, 32'h0);
        reset = 1'b0;

        vecs.push_back('{"alu",         3'b001, 32'h0000_0007, 32'h0,      5'd3,  0,           32'h0,         1'b0});
        vecs.push_back('{"alu r0",      3'b001, 32'h0000_00AA, 32'h0,      5'd0,  1,           32'h0,         1'b0});
        vecs.push_back('{"nop",         3'b000, 32'h0000_0010, 32'h0,      5'd4,  0,           32'h0,         1'b0});
        vecs.push_back('{"load",        3'b100, 32'h0000_0010, 32'h0,      5'd8,  3,           32'hDEADBEEF,  1'b0});
        vecs.push_back('{"store",       3'b010, 32'h0000_0020, 32'h1234,   5'd9,  0,           32'h5555_5555, 1'b0});
        vecs.push_back('{"illegal",     3'b110, 32'h0000_0030, 32'h0,      5'd2,  0,           32'h0,         1'b0});
        vecs.push_back('{"misaligned",  3'b100, 32'h0000_0013, 32'h0,      5'd2,  0,           32'h0,         1'b0});
        vecs.push_back('{"timeout",     3'b100, 32'h0000_0040, 32'h0,      5'd6,  TIMEOUT + 2, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{"late ack",    3'b101, 32'h0000_0044, 32'h0,      5'd7,  TIMEOUT - 1, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{"load r0",     3'b100, 32'h0000_0048, 32'h0,      5'd0,  2,           32'h1111_2222, 1'b0});
        vecs.push_back('{"busy issue",  3'b100, 32'h0000_0050, 32'h0,      5'd11, 5,           32'h7777_8888, 1'b1});
        vecs.push_back('{"store busy",  3'b011, 32'h0000_0054, 32'hABCD,   5'd12, 4,           32'h0,         1'b1});
        foreach (vecs[i])
            applyStimulus(vecs[i].name, vecs[i].ctrl, vecs[i].alu, vecs[i].wd, vecs[i].dst,
                          vecs[i].ackDelay, vecs[i].rd, vecs[i].noise);

        // Reset while a load waits in REQ must drop the request and discard the writeback.
        valid      = 1'b1;
        memctrl    = 3'b100;
        alu_result = 32'h0000_0060;
        wdata      = 32'h0;
        dest       = 5'd5;
        @(posedge clk);
        #1;
        checkOutput("rst c1", 1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst c2", 1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst c3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        checkOutput("rst c4", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        mem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        end

        for (int i = 0; i < 80; i++) begin
            d = $urandom_range(0, 9);
            b = 1'($urandom_range(0, 1));
            if (d < 2)      c = 3'b001;
            else if (d < 3) c = 3'b000;
            else if (d < 4) c = {2'b11, b};
            else            c = {b, ~b, 1'($urandom_range(0, 1))};
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 4) : $urandom_range(0, TIMEOUT + 2);
            applyStimulus($sformatf("rand%0d", i), c, a, $urandom, 5'($urandom), d, $urandom,
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Execution-side responder for the controller's memctrl command word. Accepts one command per issue from the datapath and runs a multi-cycle req/ack access on the data-memory bus. Returns load data or the ALU result to the register file, and stalls the pipeline while an access is outstanding.

Parameters:
DATA_W, 32, data and ALU-result width
ADDR_W, 32, memory byte-address width
TIMEOUT, 15, max cycles in REQ without mem_ack before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
valid  in  1  command issue strobe
memctrl  in  3  bit2=mem read, bit1=mem write, bit0=ALU-result writeback
alu_result  in  DATA_W  ALU output; memory byte address for loads and stores
wdata  in  DATA_W  store data
dest  in  5  destination register index
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_ack  in  1  bus acknowledge; mem_rdata valid when mem_ack=1
mem_rdata  in  DATA_W  bus read data
stall  out  1  unit busy; upstream holds its command
rf_we  out  1  register-file write strobe, one cycle
rf_waddr  out  5  register-file write index
rf_wdata  out  DATA_W  register-file write data
err  out  1  one-cycle error pulse

Behaviour:
- All outputs are registered. On reset, every output is 0, state=IDLE and the timeout counter is 0.
- States: IDLE, REQ, DONE. stall = (state != IDLE).
- IDLE, valid=0 or memctrl=000: no action.
- IDLE, valid=1, memctrl=001 (ALU op): next cycle rf_we=1, rf_waddr=dest, rf_wdata=alu_result. State stays IDLE (latency 1).
- IDLE, valid=1, bit2=1 or bit1=1:
  - If bit2 and bit1 are both 1 (illegal): err=1 for 1 cycle. No bus access, no rf write, stay IDLE.
  - If alu_result[1:0] != 00 (misaligned): err=1 for 1 cycle. No access, stay IDLE.
  - Otherwise: latch addr, wdata, dest and op. Next cycle mem_req=1, mem_we=bit1, mem_addr=alu_result, mem_wdata=wdata. State -> REQ, counter cleared.
  - bit0 is ignored on memory ops.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - On mem_ack: capture mem_rdata; mem_req=0 next cycle; state -> DONE.
  - No ack: counter increments each cycle. When the counter reaches TIMEOUT: mem_req=0, err=1 for 1 cycle, no rf write, state -> IDLE.
- DONE (1 cycle):
  - Load: rf_we=1, rf_waddr=latched dest, rf_wdata=captured rdata.
  - Store: no rf write.
  - State -> IDLE.
- Load latency: valid at cycle 0, mem_req at cycle 1, ack at cycle k, rf_we at cycle k+2; stall deasserts at cycle k+2.
- dest=0: rf_we is suppressed for both ALU and load writebacks, because r0 is hardwired zero. The bus access still occurs.
- valid while stall=1 is ignored; upstream must hold the command until stall=0.
- mem_ack outside REQ is ignored.
- Reset mid-access: on the next edge, mem_req=0, state=IDLE and the pending rf write is discarded.
- rf_we and err never assert in the same cycle.

Test Plan:
- ALU writeback: valid, memctrl=001, alu_result=0x0000_0007, dest=3 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=7. stall never asserts.
- Load: memctrl=100, alu_result=0x10, dest=8; ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF:
  - mem_req=1 and mem_we=0 at addr 0x10 until ack.
  - rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF one cycle after DONE.
  - stall high for the whole interval.
- Store: memctrl=010, alu_result=0x20, wdata=0x1234; ack same cycle mem_req rises -> mem_we=1, mem_wdata=0x1234, no rf_we, stall drops 2 cycles after ack.
- Errors:
  - memctrl=110 -> err pulse, mem_req stays 0.
  - memctrl=100 with alu_result=0x13 -> err pulse, no access.
  - Load with no ack -> mem_req drops and err pulses after 15 cycles; rf_we stays 0.
- Boundary:
  - Load with dest=0 and ack -> bus access completes, rf_we stays 0.
  - Second valid issued while stall=1 -> ignored.
  - reset asserted during REQ -> mem_req=0 and stall=0 next cycle, no rf_we.
